// File: rtl/false_color.sv
// false_color: maps each pixel's luminance through an 8-anchor programmable
// palette, interpolating linearly between anchors, to produce false-colour RGB.
// Palette and enable are written into shadow copies at any time and move to
// the active copies only on a frame_en strobe, so a frame never mixes palettes.
//
// Ports:
//   clk          pixel clock, all logic on posedge
//   rst          asynchronous active-low reset
//   enable       requested colorize enable (shadowed every cycle)
//   frame_en     frame-boundary strobe, commits shadow to active
//   in_valid     pixel qualifier
//   in_R/G/B     input pixel
//   cfg_wr       palette write request
//   cfg_addr     anchor index 0..7
//   cfg_data     anchor colour {R,G,B}
//   cfg_ack      one-cycle acknowledge of cfg_wr
//   cfg_pending  shadow state not yet committed to active
//   out_valid    in_valid delayed by LATENCY clocks
//   out_R/G/B    output pixel (colorized or pass-through)
module false_color #(
  parameter int unsigned SEG_BITS = 5,
  parameter int unsigned LATENCY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_en,
  input  logic        in_valid,
  input  logic [7:0]  in_R,
  input  logic [7:0]  in_G,
  input  logic [7:0]  in_B,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [23:0] cfg_data,
  output logic        cfg_ack,
  output logic        cfg_pending,
  output logic        out_valid,
  output logic [7:0]  out_R,
  output logic [7:0]  out_G,
  output logic [7:0]  out_B
);

  logic [23:0] sh_pal  [8];
  logic [23:0] act_pal [8];
  logic        sh_en;
  logic        act_en;

  // Stage registers
  logic [LATENCY-1:0] vld;
  logic [7:0]         y1;
  logic [23:0]        rgb1;
  logic [23:0]        lo2;
  logic [23:0]        hi2;
  logic [4:0]         frac2;
  logic [23:0]        rgb2;

  logic [9:0] ysum;
  logic [2:0] seg;

  // lo + floor((hi-lo)*frac / 32), clamped to 0..255
  function automatic logic [7:0] interp(input logic [7:0] lo, input logic [7:0] hi,
                                        input logic [4:0] frac);
    logic signed [8:0]  d;
    logic signed [13:0] p;
    logic signed [9:0]  o;
    d = $signed({1'b0, hi}) - $signed({1'b0, lo});
    p = d * $signed({1'b0, frac});
    o = $signed({2'b00, lo}) + $signed({p[13], p[13:5]});
    if (o < 0)
      interp = '0;
    else if (o > 10'sd255)
      interp = '1;
    else
      interp = o[7:0];
  endfunction

  assign ysum      = {2'b00, in_R} + {1'b0, in_G, 1'b0} + {2'b00, in_B};
  assign seg       = y1[7:SEG_BITS];
  assign out_valid = vld[LATENCY-1];

  // Palette shadow/active. A write coinciding with a commit lands in shadow
  // only, since the commit copies the pre-edge shadow contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < 8; k++) begin
        sh_pal[k]  <= {3{8'(36 * k)}};
        act_pal[k] <= {3{8'(36 * k)}};
      end
      sh_en       <= 1'b0;
      act_en      <= 1'b0;
      cfg_ack     <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      if (frame_en) begin
        act_pal <= sh_pal;
        act_en  <= sh_en;
      end
      if (cfg_wr)
        sh_pal[cfg_addr] <= cfg_data;
      sh_en   <= enable;
      cfg_ack <= cfg_wr;
      // On commit, active_en becomes sh_en, so an enable already differing
      // from sh_en keeps pending set.
      if (frame_en)
        cfg_pending <= cfg_wr | (enable != sh_en);
      else
        cfg_pending <= cfg_pending | cfg_wr | (enable != act_en);
    end
  end

  // Three-stage pixel pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld   <= '0;
      y1    <= '0;
      rgb1  <= '0;
      lo2   <= '0;
      hi2   <= '0;
      frac2 <= '0;
      rgb2  <= '0;
      out_R <= '0;
      out_G <= '0;
      out_B <= '0;
    end else begin
      vld  <= {vld[LATENCY-2:0], in_valid};
      // Stage 1: luminance
      y1   <= ysum[9:2];
      rgb1 <= {in_R, in_G, in_B};
      // Stage 2: anchor fetch; top segment is flat
      lo2   <= act_pal[seg];
      hi2   <= (seg == 3'd7) ? act_pal[7] : act_pal[seg + 3'd1];
      frac2 <= y1[SEG_BITS-1:0];
      rgb2  <= rgb1;
      // Stage 3: interpolate or pass through
      if (act_en) begin
        out_R <= interp(lo2[23:16], hi2[23:16], frac2);
        out_G <= interp(lo2[15:8],  hi2[15:8],  frac2);
        out_B <= interp(lo2[7:0],   hi2[7:0],   frac2);
      end else begin
        out_R <= rgb2[23:16];
        out_G <= rgb2[15:8];
        out_B <= rgb2[7:0];
      end
    end
  end

endmodule

// File: tb/tb_false_color.sv
// Testbench for false_color: directed stimulus with literal expectations plus
// a per-cycle comparison against a behavioural palette/interpolation model.
module tb_false_color;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, frame_en, in_valid, cfg_wr;
  logic [7:0]  in_R, in_G, in_B;
  logic [2:0]  cfg_addr;
  logic [23:0] cfg_data;
  logic        cfg_ack, cfg_pending, out_valid;
  logic [7:0]  out_R, out_G, out_B;

  false_color #(.SEG_BITS(5), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_en(frame_en),
    .in_valid(in_valid), .in_R(in_R), .in_G(in_G), .in_B(in_B),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ack(cfg_ack), .cfg_pending(cfg_pending), .out_valid(out_valid),
    .out_R(out_R), .out_G(out_G), .out_B(out_B)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int H = 4096;
  logic [23:0] h_rgb [H];
  bit          h_v   [H];
  bit          h_wr  [H];
  bit          h_en  [H];
  logic [23:0] h_pal [H][8];

  logic [23:0] m_sh [8];
  logic [23:0] m_act [8];
  bit m_sh_en, m_act_en, m_pend;
  int n = 0;     // posedge count while out of reset
  int base = 0;  // value of n at the last reset

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_sh[k]  = {3{8'(36 * k)}};
      m_act[k] = {3{8'(36 * k)}};
    end
    m_sh_en = 0; m_act_en = 0; m_pend = 0;
    base = n;
  endtask

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    if (rst === 1'b1 && n < H - 1) begin
      n++;
      h_rgb[n] = {in_R, in_G, in_B};
      h_v[n]   = in_valid;
      h_wr[n]  = cfg_wr;
      h_en[n]  = m_act_en;
      for (int k = 0; k < 8; k++) h_pal[n][k] = m_act[k];
      if (frame_en) begin
        m_act    = m_sh;
        m_act_en = m_sh_en;
        m_pend   = cfg_wr || (enable != m_act_en);
      end else begin
        m_pend = m_pend || cfg_wr || (enable != m_act_en);
      end
      if (cfg_wr) m_sh[cfg_addr] = cfg_data;
      m_sh_en = enable;
    end
  end

  function automatic int interp_m(int lo, int hi, int f);
    int p, q;
    p = (hi - lo) * f;
    q = (p >= 0) ? p / 32 : -((-p + 31) / 32);
    q = lo + q;
    if (q < 0) q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  // Output after posedge k: pixel from edge k-2, palette seen at edge k-1,
  // enable seen at edge k.
  function automatic logic [23:0] model_out(int k);
    int r, g, b, y, s, f;
    logic [23:0] px, lo, hi;
    px = h_rgb[k-2];
    if (!h_en[k]) return px;
    r = px[23:16]; g = px[15:8]; b = px[7:0];
    y = (r + 2 * g + b) / 4;
    s = y / 32;
    f = y % 32;
    lo = h_pal[k-1][s];
    hi = h_pal[k-1][(s == 7) ? 7 : s + 1];
    return {8'(interp_m(lo[23:16], hi[23:16], f)),
            8'(interp_m(lo[15:8],  hi[15:8],  f)),
            8'(interp_m(lo[7:0],   hi[7:0],   f))};
  endfunction

  // Compare process
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      logic        ev;
      logic [23:0] ed;
      if (n >= base + 3) begin
        ev = h_v[n-2];
        ed = model_out(n);
      end else begin
        ev = 1'b0;
        ed = '0;
      end
      chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
      if (ev || n < base + 3) chk("out_rgb", {8'b0, out_R, out_G, out_B}, {8'b0, ed});
      chk("cfg_ack", {31'b0, cfg_ack}, {31'b0, (n > base) ? h_wr[n] : 1'b0});
      chk("cfg_pending", {31'b0, cfg_pending}, {31'b0, m_pend});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic commit();
    frame_en = 1; @(negedge clk); frame_en = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [23:0] d, input logic fe);
    cfg_wr = 1; cfg_addr = a; cfg_data = d; frame_en = fe;
    @(negedge clk);
    cfg_wr = 0; frame_en = 0;
    chk("ack_literal", {31'b0, cfg_ack}, 32'd1);
  endtask

  task automatic pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [23:0] e, input string nm);
    bit found = 0;
    in_valid = 1; in_R = r; in_G = g; in_B = b;
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1;
        chk(nm, {8'b0, out_R, out_G, out_B}, {8'b0, e});
      end
    end
    if (!found) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    model_reset();
    rst = 0; enable = 0; frame_en = 0; in_valid = 0; cfg_wr = 0;
    in_R = 0; in_G = 0; in_B = 0; cfg_addr = 0; cfg_data = 0;
    #12;
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_rgb", {8'b0, out_R, out_G, out_B}, 32'd0);
    chk("reset_ack_pend", {30'b0, cfg_ack, cfg_pending}, 32'd0);
    @(negedge clk); rst = 1;
    @(negedge clk);

    // 1: pass-through
    pixel(8'd100, 8'd100, 8'd100, 24'h646464, "t1_passthru");

    // 2: default ramp, top segment flat
    enable = 1;
    repeat (2) @(negedge clk);
    chk("t2_pend_set", {31'b0, cfg_pending}, 32'd1);
    commit();
    chk("t2_pend_clr", {31'b0, cfg_pending}, 32'd0);
    pixel(8'd255, 8'd255, 8'd255, 24'hFCFCFC, "t2_top");

    // 3: positive interpolation
    wr(3'd0, 24'h000000, 1'b0);
    wr(3'd1, 24'hFF0000, 1'b0);
    commit();
    pixel(8'd31, 8'd31, 8'd31, {8'd247, 8'd0, 8'd0}, "t3_interp");

    // 4: negative slope, floor
    wr(3'd0, 24'hFF00FF, 1'b0);
    wr(3'd1, 24'h000000, 1'b0);
    commit();
    pixel(8'd1, 8'd1, 8'd1, {8'd247, 8'd0, 8'd247}, "t4_floor");

    // 5: write coinciding with commit stays in shadow
    wr(3'd2, 24'h102030, 1'b1);
    chk("t5_pend", {31'b0, cfg_pending}, 32'd1);
    pixel(8'd64, 8'd64, 8'd64, 24'h484848, "t5_old_anchor");
    commit();
    chk("t5_pend_clr", {31'b0, cfg_pending}, 32'd0);
    pixel(8'd64, 8'd64, 8'd64, 24'h102030, "t5_new_anchor");

    // 6: enable change waits for frame_en; async reset
    enable = 0;
    repeat (3) @(negedge clk);
    pixel(8'd64, 8'd64, 8'd64, 24'h102030, "t6_still_on");
    commit();
    pixel(8'd200, 8'd100, 8'd50, {8'd200, 8'd100, 8'd50}, "t6_off");
    in_valid = 1; in_R = 9; in_G = 9; in_B = 9;
    repeat (4) @(negedge clk);
    @(posedge clk); #2 rst = 0;
    #1;
    chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_rgb", {8'b0, out_R, out_G, out_B}, 32'd0);
    @(negedge clk); rst = 1; in_valid = 0;
    @(negedge clk);
    pixel(8'd10, 8'd20, 8'd30, {8'd10, 8'd20, 8'd30}, "t6_after_rst");
    enable = 1;
    repeat (2) @(negedge clk);
    commit();
    pixel(8'd64, 8'd64, 8'd64, 24'h484848, "t6_default_ramp");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
